// File: rtl/input_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer_pkg
// Description : Shared FSM state encoding and default parameter constants
//               for the input debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package input_debouncer_pkg;

  // Stable levels and their qualification (wait) states
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam int unsigned c_DEF_SYNC_STAGES     = 2;
  localparam int unsigned c_DEF_DEBOUNCE_CYCLES = 1000;
  localparam int unsigned c_DEF_CNT_WIDTH       = 16;
  localparam logic        c_DEF_RESET_VAL       = 1'b0;

endpackage : input_debouncer_pkg
`default_nettype wire

// File: rtl/input_debouncer_sync.sv
`default_nettype none
// ============================================================================
// Module      : bit_synchronizer
// Description : Generic single-bit multi-flop synchronizer with an
//               asynchronous active-low reset to a programmable level.
// Revision    : 1.0 - initial release
// ============================================================================
module bit_synchronizer #(
  parameter int unsigned STAGES    = 2,
  parameter logic        RESET_VAL = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] r_sync;

  // Shift the asynchronous input through the flop chain
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_sync <= {STAGES{RESET_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], d};
    end
  end

  assign q = r_sync[STAGES-1];

endmodule : bit_synchronizer
`default_nettype wire

// File: rtl/input_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : input_debouncer
// Description : Synchronizes a bouncy level input and accepts a level change
//               only after DEBOUNCE_CYCLES consecutive stable cycles.
//               Produces a clean level plus one-cycle rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module input_debouncer
  import input_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = c_DEF_SYNC_STAGES,
  parameter int unsigned DEBOUNCE_CYCLES = c_DEF_DEBOUNCE_CYCLES,
  parameter int unsigned CNT_WIDTH       = c_DEF_CNT_WIDTH,
  parameter logic        RESET_VAL       = c_DEF_RESET_VAL
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic din_raw,
  output logic d_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic busy
);

  // Count value on which a candidate change is accepted
  localparam logic [CNT_WIDTH-1:0] c_CNT_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam state_t               c_RST_STATE = RESET_VAL ? STABLE_HI : STABLE_LO;

  logic                 w_sync_s;
  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic                 r_d_out;
  logic                 w_d_out_nxt;
  logic                 r_rise;
  logic                 w_rise_nxt;
  logic                 r_fall;
  logic                 w_fall_nxt;
  logic                 r_busy;

  bit_synchronizer #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clock (clock),
    .reset (reset),
    .d     (din_raw),
    .q     (w_sync_s)
  );

  // Next-state, counter and output decode; enable low parks in the stable
  // state matching the current clean level, aborting any qualification.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_d_out_nxt = r_d_out;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    if (!enable) begin
      w_state_nxt = r_d_out ? STABLE_HI : STABLE_LO;
      w_cnt_nxt   = '0;
    end else begin
      case (r_state)
        STABLE_LO: begin
          if (w_sync_s) begin
            w_state_nxt = WAIT_HI;
            w_cnt_nxt   = '0;
          end
        end
        WAIT_HI: begin
          if (!w_sync_s) begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
            w_d_out_nxt = 1'b1;
            w_rise_nxt  = 1'b1;
          end else begin
            // Saturating increment: the count never passes the accept value
            w_cnt_nxt = (r_cnt < c_CNT_LAST) ? r_cnt + 1'b1 : c_CNT_LAST;
          end
        end
        STABLE_HI: begin
          if (!w_sync_s) begin
            w_state_nxt = WAIT_LO;
            w_cnt_nxt   = '0;
          end
        end
        WAIT_LO: begin
          if (w_sync_s) begin
            w_state_nxt = STABLE_HI;
            w_cnt_nxt   = '0;
          end else if (r_cnt == c_CNT_LAST) begin
            w_state_nxt = STABLE_LO;
            w_cnt_nxt   = '0;
            w_d_out_nxt = 1'b0;
            w_fall_nxt  = 1'b1;
          end else begin
            w_cnt_nxt = (r_cnt < c_CNT_LAST) ? r_cnt + 1'b1 : c_CNT_LAST;
          end
        end
        default: begin
          w_state_nxt = c_RST_STATE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // State, counter and registered outputs; busy tracks the next state so it
  // is high exactly while the FSM sits in a WAIT state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= c_RST_STATE;
      r_cnt   <= '0;
      r_d_out <= RESET_VAL;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_d_out <= w_d_out_nxt;
      r_rise  <= w_rise_nxt;
      r_fall  <= w_fall_nxt;
      r_busy  <= (w_state_nxt == WAIT_HI) || (w_state_nxt == WAIT_LO);
    end
  end

  assign d_out      = r_d_out;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign busy       = r_busy;

endmodule : input_debouncer
`default_nettype wire
